// File: rtl/rgb_stream_framer.sv
// Buffers the converter's free-running RGB stream in a FWFT FIFO and presents
// it on a valid/ready port, tagged with start-of-frame / end-of-line / end-of-frame.
module rgb_stream_framer #(
  parameter int WIDTH      = 256,
  parameter int HEIGHT     = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        pix_r,
  input  logic [7:0]                        pix_g,
  input  logic [7:0]                        pix_b,
  input  logic                              pix_valid,
  output logic [23:0]                       out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_sof,
  output logic                              out_eol,
  output logic                              out_eof,
  output logic                              frame_done,
  output logic                              overflow,
  input  logic                              clr_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int X_W   = $clog2(WIDTH);
  localparam int Y_W   = $clog2(HEIGHT);

  typedef enum logic {
    IDLE,
    ACTIVE
  } frame_state_e;

  logic [23:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, overflow_d;
  frame_state_e     state_q, state_d;

  logic push, pop, drop;
  logic at_eol, at_last_line;

  // A full FIFO can still take a pixel when the head leaves in the same cycle.
  always_comb begin
    pop  = (level_q != '0) && out_ready;
    push = pix_valid && ((level_q < LVL_W'(FIFO_DEPTH)) || pop);
    drop = pix_valid && !push;
  end

  always_comb begin
    at_eol       = (x_q == X_W'(WIDTH - 1));
    at_last_line = (y_q == Y_W'(HEIGHT - 1));
    out_valid    = (level_q != '0);
    out_data     = out_valid ? mem_q[rd_ptr_q] : 24'h0;
    out_sof      = out_valid && (x_q == '0) && (y_q == '0);
    out_eol      = out_valid && at_eol;
    out_eof      = out_valid && at_eol && at_last_line;
    frame_done   = frame_done_q;
    overflow     = overflow_q;
    fifo_level   = level_q;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = pop && out_eof;
    overflow_d   = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);

    // Raster position belongs to the head pixel, so it only moves on a pop.
    if (pop) begin
      if (at_eol) begin
        x_d = '0;
        y_d = at_last_line ? '0 : y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end

    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop && out_sof) state_d = ACTIVE;
      ACTIVE:  if (pop && out_eof) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {pix_r, pix_g, pix_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      state_q      <= IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
    end
  end

endmodule
